mem_responder: RTL

- Synthesizable memory-side responder for the tagged BUS_LOAD/BUS_STORE protocol that the instruction and data caches use as initiators.
- Accepts one command per cycle and returns a nonzero transaction tag in the same cycle.
- Returns load data with that tag a fixed number of cycles later.
- Caps outstanding loads and refuses requests (response 0) when full.
- Sits between the cache(s) or arbiter and the backing storage. Replaces the behavioural memory model in synthesis and FPGA builds.

---
 rtl/mem_responder_pkg.sv | 26 ++
 rtl/mem_responder_if.sv | 24 ++
 rtl/mem_responder_slot_tracker.sv | 87 ++++++++
 rtl/mem_responder.sv | 71 +++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the tagged BUS_LOAD/BUS_STORE memory responder.
package mem_responder_pkg;

  localparam int XLEN               = 32;
  localparam int MEM_TAG_BITS       = 4;
  localparam int MEM_WORD_ADDR_BITS = 13;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } bus_command_t;

  typedef struct packed {
    logic                    valid;
    logic [MEM_TAG_BITS-1:0] tag;
    logic [3:0]              countdown;
    logic [63:0]             data;
  } mem_slot_t;

  // Tag 0 means "no transaction", so the counter skips it on wrap.
  function automatic logic [MEM_TAG_BITS-1:0] tag_advance(input logic [MEM_TAG_BITS-1:0] t);
    return (t == 4'd15) ? 4'd1 : t + 4'd1;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Initiator <-> memory bus. A command is offered for one cycle; a nonzero
// mem2proc_response in that same cycle means accepted with that tag, 0 means
// refused (no side effects). Load data comes back later on mem2proc_tag/data.
interface mem_responder_if;
  import mem_responder_pkg::*;

  bus_command_t            proc2mem_command;
  logic [XLEN-1:0]         proc2mem_addr;
  logic [63:0]             proc2mem_data;
  logic [MEM_TAG_BITS-1:0] mem2proc_response;
  logic [63:0]             mem2proc_data;
  logic [MEM_TAG_BITS-1:0] mem2proc_tag;

  modport master (
    output proc2mem_command, proc2mem_addr, proc2mem_data,
    input  mem2proc_response, mem2proc_data, mem2proc_tag
  );

  modport slave (
    input  proc2mem_command, proc2mem_addr, proc2mem_data,
    output mem2proc_response, mem2proc_data, mem2proc_tag
  );

endinterface

// File: rtl/mem_responder_slot_tracker.sv
// In-flight load slots: lowest-free allocation, per-cycle countdown, and
// one-cycle return of the slot whose countdown has reached zero.
module mem_slot_tracker
  import mem_responder_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int MEM_LATENCY     = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    alloc_i,
  input  logic [MEM_TAG_BITS-1:0] alloc_tag_i,
  input  logic [63:0]             alloc_data_i,
  output logic                    free_o,
  output logic [MEM_TAG_BITS-1:0] ret_tag_o,
  output logic [63:0]             ret_data_o
);

  localparam logic [3:0] CD_INIT = 4'(MEM_LATENCY - 1);

  mem_slot_t slots_q [MAX_OUTSTANDING];
  mem_slot_t slots_d [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] retiring;
  logic [MAX_OUTSTANDING-1:0] reusable;

  // A slot returning this cycle is free for a new allocation at the same edge.
  always_comb begin
    retiring = '0;
    reusable = '0;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      retiring[i] = slots_q[i].valid && (slots_q[i].countdown == 4'd0);
      reusable[i] = !slots_q[i].valid || retiring[i];
    end
  end

  assign free_o = |reusable;

  always_comb begin
    ret_tag_o  = '0;
    ret_data_o = '0;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (retiring[i]) begin
        ret_tag_o  = slots_q[i].tag;
        ret_data_o = slots_q[i].data;
      end
    end
  end

  always_comb begin
    logic placed;
    placed = 1'b0;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      slots_d[i] = slots_q[i];
      if (retiring[i]) begin
        slots_d[i] = '0;
      end else if (slots_q[i].valid) begin
        slots_d[i].countdown = slots_q[i].countdown - 4'd1;
      end
      if (alloc_i && !placed && reusable[i]) begin
        slots_d[i].valid     = 1'b1;
        slots_d[i].tag       = alloc_tag_i;
        slots_d[i].countdown = CD_INIT;
        slots_d[i].data      = alloc_data_i;
        placed               = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (rst_i) slots_q[i] <= '0;
      else       slots_q[i] <= slots_d[i];
    end
  end

  always @(posedge clk_i) begin
    if (!rst_i) begin
      assert ($countones(retiring) <= 1);
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        for (int j = i + 1; j < MAX_OUTSTANDING; j++) begin
          assert (!(slots_q[i].valid && slots_q[j].valid && (slots_q[i].tag == slots_q[j].tag)));
        end
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: backing store, address check, tag counter and
// same-cycle response; load returns are delegated to the slot tracker.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int MEM_LATENCY     = 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter int MEM_WORDS       = 8192
) (
  input  logic           clock,
  input  logic           reset,
  mem_responder_if.slave bus
);

  logic [63:0]                   mem_q [MEM_WORDS];
  logic [MEM_TAG_BITS-1:0]       next_tag_q;
  logic [MEM_TAG_BITS-1:0]       next_tag_d;
  logic [MEM_WORD_ADDR_BITS-1:0] word_idx;
  logic                          addr_ok;
  logic                          is_load;
  logic                          is_store;
  logic                          slot_free;
  logic                          accept;
  logic                          accept_load;
  logic                          unused_addr_bits;

  assign word_idx         = bus.proc2mem_addr[15:3];
  assign addr_ok          = (bus.proc2mem_addr[XLEN-1:16] == '0);
  assign unused_addr_bits = ^bus.proc2mem_addr[2:0];
  assign is_load          = (bus.proc2mem_command == BUS_LOAD);
  assign is_store         = (bus.proc2mem_command == BUS_STORE);

  assign accept      = !reset && addr_ok && (is_store || (is_load && slot_free));
  assign accept_load = accept && is_load;

  assign bus.mem2proc_response = accept ? next_tag_q : '0;

  always_comb begin
    next_tag_d = next_tag_q;
    if (accept) next_tag_d = tag_advance(next_tag_q);
  end

  always_ff @(posedge clock) begin
    if (reset) next_tag_q <= 4'd1;
    else       next_tag_q <= next_tag_d;
  end

  // Storage is deliberately not reset; contents survive a responder reset.
  always_ff @(posedge clock) begin
    if (accept && is_store) mem_q[word_idx] <= bus.proc2mem_data;
  end

  mem_slot_tracker #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING),
    .MEM_LATENCY    (MEM_LATENCY)
  ) u_slots (
    .clk_i       (clock),
    .rst_i       (reset),
    .alloc_i     (accept_load),
    .alloc_tag_i (next_tag_q),
    .alloc_data_i(mem_q[word_idx]),
    .free_o      (slot_free),
    .ret_tag_o   (bus.mem2proc_tag),
    .ret_data_o  (bus.mem2proc_data)
  );

  always @(posedge clock) begin
    if (!reset) assert ((bus.mem2proc_response == '0) || (bus.proc2mem_command != BUS_NONE));
  end

endmodule
